// File: rtl/dnn_acc_pkg.sv
// Shared types, drain FSM encoding and the output post-processing function
// for the dnn_acc_array MAC lane array.
package dnn_acc_pkg;

    // Widest containers; the array's ACC_W and OW parameters must fit inside them.
    localparam int unsigned ACC_MAX_W = 64;
    localparam int unsigned OUT_MAX_W = 32;

    typedef logic signed [ACC_MAX_W-1:0] acc_t;
    typedef logic signed [OUT_MAX_W-1:0] out_t;

    typedef enum logic {
        DRAIN_IDLE   = 1'b0,
        DRAIN_ACTIVE = 1'b1
    } drain_state_e;

    // Arithmetic shift, optional ReLU, then saturation to an ow-bit signed range.
    function automatic out_t post_proc(input acc_t        val,
                                       input logic [5:0]  shift,
                                       input logic        relu,
                                       input int unsigned ow);
        acc_t y;
        acc_t hi;
        acc_t lo;
        y  = val >>> shift;
        if (relu && y[ACC_MAX_W-1]) y = '0;
        hi = (acc_t'(1) <<< (ow - 1)) - acc_t'(1);
        lo = ~hi;
        if (y > hi)      y = hi;
        else if (y < lo) y = lo;
        return out_t'(y);
    endfunction

endpackage

// File: rtl/dnn_acc_if.sv
// Drain stream from the lane array to the destination buffer.
// A beat transfers on every rising clk edge where dst_valid && dst_ready; while dst_valid
// is high and dst_ready low, dst_data and dst_last hold steady, and dst_valid never drops
// before its beat transfers.
interface dnn_acc_if #(
    parameter int OW = 16
);
    logic                 dst_valid;
    logic                 dst_ready;
    logic                 dst_last;
    logic signed [OW-1:0] dst_data;

    modport master (output dst_valid, output dst_data, output dst_last, input  dst_ready);
    modport slave  (input  dst_valid, input  dst_data, input  dst_last, output dst_ready);
endinterface

// File: rtl/dnn_acc_lane.sv
// One filter lane: weight RAM, bias register, stage-2 MAC, accumulator and
// the shadow register the drain reads from.
module dnn_acc_lane #(
    parameter int DW     = 16,
    parameter int ACC_W  = 40,
    parameter int WDEPTH = 1024,
    parameter int WA_W   = $clog2(WDEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ram_we_i,
    input  logic                    bias_we_i,
    input  logic [WA_W-1:0]         wr_addr_i,
    input  logic signed [DW-1:0]    wr_data_i,
    input  logic [WA_W-1:0]         ra_i,
    input  logic signed [DW-1:0]    d_q_i,
    input  logic                    exec_q_i,
    input  logic                    k_init_i,
    input  logic                    enbias_i,
    input  logic                    commit_i,
    output logic signed [ACC_W-1:0] final_o,
    output logic signed [ACC_W-1:0] shadow_o
);

    logic signed [DW-1:0]    mem [WDEPTH];
    logic signed [DW-1:0]    w_q;
    logic signed [DW-1:0]    bias_q;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] inc;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] shadow_q, shadow_d;

    // Weights and bias are parameters loaded once; they survive a reset.
    always_ff @(posedge clk) begin
        if (ram_we_i)  mem[wr_addr_i] <= wr_data_i;
        if (bias_we_i) bias_q <= wr_data_i;
        w_q <= mem[ra_i];
    end

    assign prod = w_q * d_q_i;

    always_comb begin
        inc      = exec_q_i ? ACC_W'(prod) : '0;
        bias_ext = enbias_i ? ACC_W'(bias_q) : '0;
        final_o  = acc_q + inc + bias_ext;
        acc_d    = k_init_i ? inc : acc_q + inc;
        shadow_d = commit_i ? final_o : shadow_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            shadow_q <= '0;
        end else begin
            acc_q    <= acc_d;
            shadow_q <= shadow_d;
        end
    end

    assign shadow_o = shadow_q;

endmodule

// File: rtl/dnn_acc_array.sv
// F_NUM-lane signed MAC array with a double-buffered shadow bank drained
// lane 0 first as a post-processed valid/ready stream.
module dnn_acc_array
    import dnn_acc_pkg::*;
#(
    parameter  int F_NUM  = 16,
    parameter  int DW     = 16,
    parameter  int ACC_W  = 40,
    parameter  int OW     = 16,
    parameter  int WDEPTH = 1024,
    parameter  int WA_W   = $clog2(WDEPTH),
    localparam int LANE_W = (F_NUM > 1) ? $clog2(F_NUM) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_relu,
    input  logic                 cfg_enbias,
    input  logic [5:0]           cfg_shift,
    input  logic                 wr_en,
    input  logic                 wr_bias,
    input  logic [LANE_W-1:0]    wr_lane,
    input  logic [WA_W-1:0]      wr_addr,
    input  logic signed [DW-1:0] wr_data,
    input  logic                 k_init,
    input  logic                 exec,
    input  logic [WA_W-1:0]      ra,
    input  logic signed [DW-1:0] d,
    input  logic                 k_fin,
    output logic                 busy,
    output logic                 err,
    output drain_state_e         dbg_state,
    dnn_acc_if.master            dst
);

    logic signed [DW-1:0]    d_q;
    logic                    exec_q, kfin_q;
    logic                    shadow_full_q, shadow_full_d;
    logic                    err_q, err_d;
    logic                    valid_w, last_acc, commit;
    logic signed [ACC_W-1:0] final_v  [F_NUM];
    logic signed [ACC_W-1:0] shadow_v [F_NUM];

    drain_state_e            state_q, state_d;
    logic [LANE_W-1:0]       ptr_q, ptr_d, ptr_inc;
    logic                    last_q, last_d, load;
    logic signed [OW-1:0]    data_q, data_d;
    logic signed [ACC_W-1:0] pp_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q    <= '0;
            exec_q <= 1'b0;
            kfin_q <= 1'b0;
        end else begin
            d_q    <= d;
            exec_q <= exec;
            kfin_q <= k_fin;
        end
    end

    for (genvar i = 0; i < F_NUM; i++) begin : g_lane
        logic sel;
        assign sel = wr_en && (wr_lane == LANE_W'(i));

        dnn_acc_lane #(
            .DW    (DW),
            .ACC_W (ACC_W),
            .WDEPTH(WDEPTH),
            .WA_W  (WA_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .ram_we_i (sel & ~wr_bias),
            .bias_we_i(sel & wr_bias),
            .wr_addr_i(wr_addr),
            .wr_data_i(wr_data),
            .ra_i     (ra),
            .d_q_i    (d_q),
            .exec_q_i (exec_q),
            .k_init_i (k_init),
            .enbias_i (cfg_enbias),
            .commit_i (commit),
            .final_o  (final_v[i]),
            .shadow_o (shadow_v[i])
        );
    end

    // The shadow bank frees up in the very cycle its last beat is accepted,
    // so a commit landing on that handshake is legal.
    assign valid_w  = (state_q == DRAIN_ACTIVE);
    assign last_acc = valid_w & dst.dst_ready & last_q;
    assign busy     = shadow_full_q & ~last_acc;
    assign commit   = kfin_q & ~busy;
    assign err_d    = err_q | (kfin_q & busy);

    always_comb begin
        shadow_full_d = shadow_full_q;
        if (commit)        shadow_full_d = 1'b1;
        else if (last_acc) shadow_full_d = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        load    = 1'b0;
        pp_src  = shadow_v[0];
        ptr_inc = ptr_q + LANE_W'(1);
        unique case (state_q)
            DRAIN_IDLE: begin
                if (shadow_full_q) begin
                    state_d = DRAIN_ACTIVE;
                    ptr_d   = '0;
                    load    = 1'b1;
                    last_d  = (F_NUM == 1);
                end
            end
            DRAIN_ACTIVE: begin
                if (dst.dst_ready) begin
                    if (!last_q) begin
                        ptr_d  = ptr_inc;
                        pp_src = shadow_v[ptr_inc];
                        load   = 1'b1;
                        last_d = (ptr_inc == LANE_W'(F_NUM - 1));
                    end else if (commit) begin
                        // Back-to-back kernel: shadow is written this edge, so take lane 0 from the commit path.
                        ptr_d  = '0;
                        pp_src = final_v[0];
                        load   = 1'b1;
                        last_d = (F_NUM == 1);
                    end else begin
                        state_d = DRAIN_IDLE;
                        last_d  = 1'b0;
                    end
                end
            end
            default: ;
        endcase
        data_d = load ? OW'(post_proc(acc_t'(pp_src), cfg_shift, cfg_relu, OW)) : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= DRAIN_IDLE;
            ptr_q         <= '0;
            last_q        <= 1'b0;
            data_q        <= '0;
            shadow_full_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            last_q        <= last_d;
            data_q        <= data_d;
            shadow_full_q <= shadow_full_d;
            err_q         <= err_d;
        end
    end

    assign dst.dst_valid = valid_w;
    assign dst.dst_data  = data_q;
    assign dst.dst_last  = last_q;
    assign err           = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dnn_acc_array.sv
// Directed bench for dnn_acc_array: 4 lanes, 8-bit output, table-driven kernels
// plus hand sequences for backpressure, overlap, clear-and-load and reset.
module tb_dnn_acc_array;
    import dnn_acc_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               cfg_relu, cfg_enbias;
    logic [5:0]         cfg_shift;
    logic               wr_en, wr_bias;
    logic [1:0]         wr_lane;
    logic [3:0]         wr_addr, ra;
    logic signed [15:0] wr_data, d;
    logic               k_init, exec, k_fin;
    logic               busy, err;
    drain_state_e       dbg_state;

    dnn_acc_if #(.OW(8)) dst_if ();

    dnn_acc_array #(
        .F_NUM(4), .DW(16), .ACC_W(40), .OW(8), .WDEPTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_relu(cfg_relu), .cfg_enbias(cfg_enbias), .cfg_shift(cfg_shift),
        .wr_en(wr_en), .wr_bias(wr_bias), .wr_lane(wr_lane), .wr_addr(wr_addr), .wr_data(wr_data),
        .k_init(k_init), .exec(exec), .ra(ra), .d(d), .k_fin(k_fin),
        .busy(busy), .err(err), .dbg_state(dbg_state),
        .dst(dst_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int addr; int n; int d0; int d1; int d2;
        int shift; int relu; int enbias;
        int e0; int e1; int e2; int e3;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input int lane, input int addr, input int val);
        wr_en = 1'b1; wr_bias = 1'b0;
        wr_lane = 2'(lane); wr_addr = 4'(addr); wr_data = 16'(val);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic write_b(input int lane, input int val);
        wr_en = 1'b1; wr_bias = 1'b1;
        wr_lane = 2'(lane); wr_addr = '0; wr_data = 16'(val);
        tick();
        wr_en = 1'b0; wr_bias = 1'b0;
    endtask

    task automatic set_cfg(input int shift, input int relu, input int enbias);
        cfg_shift = 6'(shift); cfg_relu = (relu != 0); cfg_enbias = (enbias != 0);
    endtask

    task automatic run_kernel(input int addr, input int n, input int d0, input int d1, input int d2);
        int dv[3];
        dv = '{d0, d1, d2};
        k_init = 1'b1;
        tick();
        k_init = 1'b0;
        for (int j = 0; j < n; j++) begin
            exec = 1'b1; ra = 4'(addr + j); d = 16'(dv[j]);
            tick();
        end
        exec = 1'b0;
        k_fin = 1'b1;
        tick();
        k_fin = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!dst_if.dst_valid && n < 20) begin
            tick();
            n++;
        end
        check({nm, " valid"}, longint'(dst_if.dst_valid), 1);
    endtask

    // Drains four beats with ready held high, starting from the presented lane-0 beat.
    task automatic drain4(input string nm, input int e0, input int e1, input int e2, input int e3);
        int ex[4];
        ex = '{e0, e1, e2, e3};
        dst_if.dst_ready = 1'b1;
        wait_valid(nm);
        for (int b = 0; b < 4; b++) begin
            check($sformatf("%s beat%0d data", nm, b), longint'(dst_if.dst_data), ex[b]);
            check($sformatf("%s beat%0d last", nm, b), longint'(dst_if.dst_last), (b == 3) ? 1 : 0);
            tick();
        end
        check({nm, " valid after drain"}, longint'(dst_if.dst_valid), 0);
        check({nm, " busy after drain"}, longint'(busy), 0);
    endtask

    initial begin
        int w4[4];
        int w5[4];
        int bs[4];
        int ex[4];
        w4 = '{10, -10, 1, 0};
        w5 = '{5, 1, 2, 3};
        bs = '{-100, 5, 0, -36};

        tbl[0] = '{0, 3, 2, 3, 4,   0, 0, 0,    9,   18,  27, 36};
        tbl[1] = '{0, 3, 2, 3, 4,   0, 0, 1,  -91,   23,  27,  0};
        tbl[2] = '{0, 3, 2, 3, 4,   0, 1, 1,    0,   23,  27,  0};
        tbl[3] = '{4, 1, 100, 0, 0, 2, 0, 0,  127, -128,  25,  0};
        tbl[4] = '{4, 1, 100, 0, 0, 0, 0, 0,  127, -128, 100,  0};
        tbl[5] = '{0, 3, 2, 3, 4,   1, 0, 0,    4,    9,  13, 18};
        tbl[6] = '{4, 1, 100, 0, 0, 2, 1, 0,  127,    0,  25,  0};

        rst_n = 1'b0;
        set_cfg(0, 0, 0);
        wr_en = 1'b0; wr_bias = 1'b0; wr_lane = '0; wr_addr = '0; wr_data = '0;
        k_init = 1'b0; exec = 1'b0; ra = '0; d = '0; k_fin = 1'b0;
        dst_if.dst_ready = 1'b1;

        #12;
        check("reset dst_valid", longint'(dst_if.dst_valid), 0);
        check("reset dst_last", longint'(dst_if.dst_last), 0);
        check("reset dst_data", longint'(dst_if.dst_data), 0);
        check("reset busy", longint'(busy), 0);
        check("reset err", longint'(err), 0);
        check("reset state", longint'(dbg_state), longint'(DRAIN_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int l = 0; l < 4; l++) begin
            for (int a = 0; a < 3; a++) write_w(l, a, l + 1);
            write_w(l, 4, w4[l]);
            write_w(l, 5, w5[l]);
            write_b(l, bs[l]);
        end

        for (int i = 0; i < 7; i++) begin
            set_cfg(tbl[i].shift, tbl[i].relu, tbl[i].enbias);
            run_kernel(tbl[i].addr, tbl[i].n, tbl[i].d0, tbl[i].d1, tbl[i].d2);
            drain4($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3);
        end
        set_cfg(0, 0, 0);

        // Backpressure mid-drain, with a second k_fin while the shadow bank is busy.
        run_kernel(0, 3, 2, 3, 4);
        wait_valid("bp");
        check("bp beat0 data", longint'(dst_if.dst_data), 9);
        tick();
        dst_if.dst_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            k_init = (c == 0); exec = (c == 1); ra = 4'd4; d = 16'sd100; k_fin = (c == 2);
            tick();
            check($sformatf("bp stall%0d data", c), longint'(dst_if.dst_data), 18);
            check($sformatf("bp stall%0d last", c), longint'(dst_if.dst_last), 0);
            check($sformatf("bp stall%0d busy", c), longint'(busy), 1);
        end
        k_init = 1'b0; exec = 1'b0; k_fin = 1'b0;
        check("overlap err", longint'(err), 1);
        dst_if.dst_ready = 1'b1;
        ex = '{9, 18, 27, 36};
        for (int b = 1; b < 4; b++) begin
            check($sformatf("bp beat%0d data", b), longint'(dst_if.dst_data), ex[b]);
            check($sformatf("bp beat%0d last", b), longint'(dst_if.dst_last), (b == 3) ? 1 : 0);
            tick();
        end
        check("bp valid after drain", longint'(dst_if.dst_valid), 0);
        check("overlap err sticky", longint'(err), 1);

        // Asynchronous reset in the middle of a drain.
        run_kernel(0, 3, 2, 3, 4);
        wait_valid("rst");
        check("rst beat0 data", longint'(dst_if.dst_data), 9);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst dst_valid", longint'(dst_if.dst_valid), 0);
        check("rst busy", longint'(busy), 0);
        check("rst err", longint'(err), 0);
        check("rst dst_last", longint'(dst_if.dst_last), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst no beat", longint'(dst_if.dst_valid), 0);
        run_kernel(0, 3, 2, 3, 4);
        drain4("post_rst", 9, 18, 27, 36);

        // k_fin landing on the last handshake: no error, back-to-back drain.
        run_kernel(0, 3, 2, 3, 4);
        wait_valid("b2b");
        for (int b = 0; b < 3; b++) begin
            check($sformatf("b2b k1 beat%0d data", b), longint'(dst_if.dst_data), 9 * (b + 1));
            tick();
        end
        dst_if.dst_ready = 1'b0;
        check("b2b k1 beat3 data", longint'(dst_if.dst_data), 36);
        check("b2b k1 beat3 last", longint'(dst_if.dst_last), 1);
        k_init = 1'b1;
        tick();
        k_init = 1'b0; exec = 1'b1; ra = 4'd4; d = 16'sd100;
        tick();
        exec = 1'b0; k_fin = 1'b1;
        tick();
        k_fin = 1'b0; dst_if.dst_ready = 1'b1;
        #1;
        check("b2b busy on last accept", longint'(busy), 0);
        tick();
        check("b2b err", longint'(err), 0);
        check("b2b valid held", longint'(dst_if.dst_valid), 1);
        drain4("b2b k2", 127, -128, 100, 0);

        // Clear-and-load: k_init coincides with the stage-2 exec of w=5, d=7.
        exec = 1'b1; ra = 4'd5; d = 16'sd7;
        tick();
        exec = 1'b0; k_init = 1'b1;
        tick();
        k_init = 1'b0; k_fin = 1'b1;
        tick();
        k_fin = 1'b0;
        drain4("clr_load", 35, 7, 14, 21);
        run_kernel(5, 1, 1, 0, 0);
        drain4("clr_next", 5, 1, 2, 3);
        check("final err", longint'(err), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
